// File: rtl/iom_pkg.sv
// Shared types and decode helper for the 8088-style bus slave.
package iom_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DATA} iom_state_t;

  localparam logic IOM_MEM = 1'b0;
  localparam logic IOM_IO  = 1'b1;

  // A cycle hits when the space matches and the address lies inside the aligned window.
  function automatic logic iom_hit(input logic [31:0] addr, input logic iom,
                                   input logic [31:0] base, input int size_log2,
                                   input logic is_io);
    return (iom == is_io) && ((addr >> size_log2) == (base >> size_log2));
  endfunction

endpackage

// File: rtl/iom_wait_timer.sv
// Wait-state counter: loads WAIT_STATES-1, counts down while enabled, flags zero.
module iom_wait_timer #(
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [3:0] LOAD_VAL = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/iom_bus_slave.sv
// Decode-and-respond 8088-style bus slave with a byte array and programmable wait states.
// Optional saturating access counters are built when IOM_BUS_STATS_EN is defined.
module iom_bus_slave
  import iom_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 20,
  parameter int                SIZE_LOG2   = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'hF0000,
  parameter bit                IS_IO       = 1'b0,
  parameter int                WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              DATA_OE,
  output logic              READY,
  output logic              SEL,
  output logic [15:0]       RD_COUNT,
  output logic [15:0]       WR_COUNT,
  output iom_state_t        dbg_state
);

  localparam int DEPTH    = 2 ** SIZE_LOG2;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  iom_state_t           state, state_next;
  logic [SIZE_LOG2-1:0] offset;
  logic                 op_write, op_write_next;
  logic                 abort_q;
  logic                 hit, rd_req, wr_req, strobe_off;
  logic                 timer_load, timer_zero, strobe_stall;
  logic                 enter_data, do_write;
  logic [DATA_W-1:0]    mem [DEPTH];

  assign hit        = iom_hit(32'(ADDR), IOM, 32'(BASE_ADDR), SIZE_LOG2, IS_IO);
  assign rd_req     = !RD && WR;
  assign wr_req     = !WR && RD;
  assign strobe_off = op_write ? WR : RD;

  always_comb begin
    state_next    = state;
    op_write_next = op_write;
    timer_load    = 1'b0;
    if (ALE) begin
      state_next = hit ? iom_pkg::ADDR : IDLE;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        iom_pkg::ADDR: begin
          if (rd_req || wr_req) begin
            op_write_next = wr_req;
            if (HAS_WAIT) begin
              state_next = WAIT;
              timer_load = 1'b1;
            end else begin
              state_next = DATA;
            end
          end
        end
        WAIT: begin
          if (timer_zero) state_next = (abort_q || strobe_off) ? IDLE : DATA;
        end
        DATA: begin
          if (RD && WR) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // READY handshake: 0 holds the processor in wait states. It drops on the cycle a
  // valid strobe is seen in ADDR, stays low through WAIT, and is 1 in every other state.
  assign strobe_stall = HAS_WAIT && (state == iom_pkg::ADDR) && !ALE && (rd_req || wr_req);
  assign READY        = !((state == WAIT) || strobe_stall);
  assign SEL          = (state != IDLE);
  assign dbg_state    = state;

  assign enter_data = (state_next == DATA) && (state != DATA);
  assign do_write   = enter_data && op_write_next && !RESET;

  iom_wait_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
    .clk  (CLK),
    .reset(RESET),
    .load (timer_load),
    .dec  (state == WAIT),
    .zero (timer_zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      offset   <= '0;
      op_write <= 1'b0;
      abort_q  <= 1'b0;
      DATA_OUT <= '0;
      DATA_OE  <= 1'b0;
    end else begin
      state    <= state_next;
      op_write <= op_write_next;
      if (ALE && hit) offset <= ADDR[SIZE_LOG2-1:0];
      // A strobe released at any point during WAIT cancels the array access.
      if (timer_load) abort_q <= 1'b0;
      else if ((state == WAIT) && strobe_off) abort_q <= 1'b1;
      if (enter_data && !op_write_next) DATA_OUT <= mem[offset];
      DATA_OE <= (state_next == DATA) && !op_write_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_write) mem[offset] <= DATA_IN;
  end

`ifdef IOM_BUS_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else if (enter_data) begin
      if (!op_write_next && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if (op_write_next && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign RD_COUNT = rd_cnt;
  assign WR_COUNT = wr_cnt;
`else
  assign RD_COUNT = 16'd0;
  assign WR_COUNT = 16'd0;
`endif

endmodule

// File: tb/tb_iom_bus_slave.sv
// Bench for iom_bus_slave: a memory slave (2 wait states) and an I/O slave (0 wait
// states) share one bus and are checked against a byte-array reference model.
module tb_iom_bus_slave;
  import iom_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ale, iom, rd, wr;
  logic [19:0] addr;
  logic [7:0]  data_in;

  logic [7:0]  dout0, dout1;
  logic        oe0, oe1, rdy0, rdy1, sel0, sel1;
  logic [15:0] rdc0, rdc1, wrc0, wrc1;
  iom_state_t  dbg0, dbg1;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model_mem [int];
  int         keys_q[$];
  int         rd_m[2];
  int         wr_m[2];

  iom_bus_slave #(.BASE_ADDR(20'hF0000), .IS_IO(1'b0), .WAIT_STATES(2)) u_mem (
    .CLK(clk), .RESET(reset), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr), .ADDR(addr),
    .DATA_IN(data_in), .DATA_OUT(dout0), .DATA_OE(oe0), .READY(rdy0), .SEL(sel0),
    .RD_COUNT(rdc0), .WR_COUNT(wrc0), .dbg_state(dbg0)
  );

  iom_bus_slave #(.BASE_ADDR(20'hF0000), .IS_IO(1'b1), .WAIT_STATES(0)) u_io (
    .CLK(clk), .RESET(reset), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr), .ADDR(addr),
    .DATA_IN(data_in), .DATA_OUT(dout1), .DATA_OE(oe1), .READY(rdy1), .SEL(sel1),
    .RD_COUNT(rdc1), .WR_COUNT(wrc1), .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_slave(input int s, input string tag, input logic e_sel,
                             input logic e_rdy, input logic e_oe);
    chk({tag, (s == 0) ? "_mem_sel" : "_io_sel"}, (s == 0) ? sel0 : sel1, e_sel);
    chk({tag, (s == 0) ? "_mem_ready" : "_io_ready"}, (s == 0) ? rdy0 : rdy1, e_rdy);
    chk({tag, (s == 0) ? "_mem_oe" : "_io_oe"}, (s == 0) ? oe0 : oe1, e_oe);
  endtask

  task automatic check_quiet(input int skip, input string tag);
    for (int s = 0; s < 2; s++) if (s != skip) check_slave(s, tag, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic int target(input logic i, input logic [19:0] a);
    if (a[19:12] != 8'hF0) return -1;
    return i ? 1 : 0;
  endfunction

  task automatic check_counts(input string tag);
`ifdef IOM_BUS_STATS_EN
    chk({tag, "_rdcnt_mem"}, rdc0, 16'(rd_m[0]));
    chk({tag, "_wrcnt_mem"}, wrc0, 16'(wr_m[0]));
    chk({tag, "_rdcnt_io"}, rdc1, 16'(rd_m[1]));
    chk({tag, "_wrcnt_io"}, wrc1, 16'(wr_m[1]));
`else
    chk({tag, "_rdcnt_mem"}, rdc0, 16'd0);
    chk({tag, "_wrcnt_mem"}, wrc0, 16'd0);
    chk({tag, "_rdcnt_io"}, rdc1, 16'd0);
    chk({tag, "_wrcnt_io"}, wrc1, 16'd0);
`endif
  endtask

  // One complete bus cycle; every expectation comes from the window map and the model.
  task automatic bus_cycle(input logic i, input logic [19:0] a, input logic is_wr,
                           input logic [7:0] wdata, input bit early);
    int   tgt, ws, key;
    logic exp_rd;
    tgt    = target(i, a);
    ws     = (tgt == 0) ? 2 : 0;
    key    = tgt * 4096 + int'(a[11:0]);
    exp_rd = !is_wr && (tgt >= 0);
    @(posedge clk); #1;
    ale = 1'b1; iom = i; addr = a;
    @(negedge clk);
    check_quiet(-1, "t1");
    @(posedge clk); #1;
    ale = 1'b0; addr = 20'($urandom);
    if (is_wr) begin wr = 1'b0; data_in = wdata; end
    else rd = 1'b0;
    @(negedge clk);
    check_quiet(tgt, "strobe");
    if (tgt >= 0) check_slave(tgt, "strobe", 1'b1, (ws > 0) ? 1'b0 : 1'b1, 1'b0);
    if (early && (tgt >= 0) && (ws > 0)) begin
      @(posedge clk); #1;
      rd = 1'b1; wr = 1'b1;
      for (int k = 0; k < ws; k++) begin
        @(negedge clk);
        check_slave(tgt, "early_wait", 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      check_slave(tgt, "early_done", 1'b0, 1'b1, 1'b0);
      check_quiet(tgt, "early_done");
      return;
    end
    for (int k = 0; k < ws; k++) begin
      @(negedge clk);
      check_slave(tgt, "wait", 1'b1, 1'b0, 1'b0);
      check_quiet(tgt, "wait");
    end
    @(negedge clk);
    check_quiet(tgt, "data");
    if (tgt >= 0) begin
      check_slave(tgt, "data", 1'b1, 1'b1, exp_rd);
      if (exp_rd) begin
        rd_m[tgt]++;
        if (model_mem.exists(key)) chk("rd_data", (tgt == 0) ? dout0 : dout1, model_mem[key]);
      end else begin
        wr_m[tgt]++;
        if (!model_mem.exists(key)) keys_q.push_back(key);
        model_mem[key] = wdata;
      end
    end
    @(posedge clk); #1;
    rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    if (tgt >= 0) check_slave(tgt, "release", 1'b1, 1'b1, exp_rd);
    @(negedge clk);
    check_quiet(-1, "idle");
  endtask

  initial begin
    int         k;
    logic       ri;
    logic [19:0] ra;
    reset = 1'b1; ale = 1'b0; iom = 1'b0; rd = 1'b1; wr = 1'b1;
    addr = 20'd0; data_in = 8'd0;
    rd_m = '{0, 0}; wr_m = '{0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet(-1, "reset");
    chk("reset_dout_mem", dout0, 8'h00);
    chk("reset_dout_io", dout1, 8'h00);
    chk("reset_state_mem", dbg0, IDLE);
    check_counts("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Write then read with the default two wait states.
    bus_cycle(IOM_MEM, 20'hF0010, 1'b1, 8'hA5, 1'b0);
    bus_cycle(IOM_MEM, 20'hF0010, 1'b0, 8'h00, 1'b0);
    // I/O write to the same address must not disturb the memory slave.
    bus_cycle(IOM_IO, 20'hF0010, 1'b1, 8'h11, 1'b0);
    bus_cycle(IOM_MEM, 20'hF0010, 1'b0, 8'h00, 1'b0);
    bus_cycle(IOM_IO, 20'hF0010, 1'b0, 8'h00, 1'b0);
    // Window miss: nobody responds.
    bus_cycle(IOM_MEM, 20'hE0010, 1'b1, 8'h66, 1'b0);
    bus_cycle(IOM_MEM, 20'hE0010, 1'b0, 8'h00, 1'b0);
    // Zero wait states at the top offset.
    bus_cycle(IOM_IO, 20'hF0FFF, 1'b1, 8'h77, 1'b0);
    bus_cycle(IOM_IO, 20'hF0FFF, 1'b0, 8'h00, 1'b0);
    bus_cycle(IOM_MEM, 20'hF0000, 1'b1, 8'h01, 1'b0);
    bus_cycle(IOM_MEM, 20'hF0FFF, 1'b1, 8'hFE, 1'b0);
    bus_cycle(IOM_MEM, 20'hF0000, 1'b0, 8'h00, 1'b0);
    bus_cycle(IOM_MEM, 20'hF0FFF, 1'b0, 8'h00, 1'b0);

    // Illegal strobes hold in ADDR without writing; releasing WR turns it into a read.
    bus_cycle(IOM_MEM, 20'hF0020, 1'b1, 8'h5A, 1'b0);
    @(posedge clk); #1;
    ale = 1'b1; iom = IOM_MEM; addr = 20'hF0020;
    @(posedge clk); #1;
    ale = 1'b0; rd = 1'b0; wr = 1'b0; data_in = 8'h3C;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_slave(0, "illegal", 1'b1, 1'b1, 1'b0);
      chk("illegal_state", dbg0, ADDR);
    end
    @(posedge clk); #1;
    wr = 1'b1;
    @(negedge clk);
    check_slave(0, "illegal_strobe", 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_slave(0, "illegal_wait", 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    check_slave(0, "illegal_data", 1'b1, 1'b1, 1'b1);
    chk("illegal_rd_data", dout0, model_mem[32]);
    rd_m[0]++;
    @(posedge clk); #1;
    rd = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet(-1, "illegal_idle");

    // Strobe released during WAIT: no write lands.
    bus_cycle(IOM_MEM, 20'hF0020, 1'b1, 8'hEE, 1'b1);
    bus_cycle(IOM_MEM, 20'hF0020, 1'b0, 8'h00, 1'b0);

    // Reset during the WAIT of a write drops it.
    bus_cycle(IOM_MEM, 20'hF0030, 1'b1, 8'hC3, 1'b0);
    @(posedge clk); #1;
    ale = 1'b1; iom = IOM_MEM; addr = 20'hF0030;
    @(posedge clk); #1;
    ale = 1'b0; wr = 1'b0; data_in = 8'h99;
    @(negedge clk);
    check_slave(0, "rst_strobe", 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b1;
    rd_m = '{0, 0}; wr_m = '{0, 0};
    @(negedge clk);
    check_quiet(-1, "rst_wait");
    check_counts("rst_wait");
    bus_cycle(IOM_MEM, 20'hF0030, 1'b0, 8'h00, 1'b0);

    // Randomized traffic across both slaves and the miss region.
    for (int n = 0; n < 24; n++) begin
      if ((keys_q.size() == 0) || ($urandom_range(0, 1) == 0)) begin
        ri = 1'($urandom_range(0, 1));
        ra = {($urandom_range(0, 3) == 0) ? 8'hE0 : 8'hF0, 12'($urandom)};
        bus_cycle(ri, ra, 1'b1, 8'($urandom), 1'b0);
      end else begin
        k = keys_q[$urandom_range(0, keys_q.size() - 1)];
        bus_cycle(k >= 4096, {8'hF0, 12'(k % 4096)}, 1'b0, 8'h00, 1'b0);
      end
    end

    check_counts("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
